// File: rtl/dap_ahb_mem_bridge.sv
// dap_ahb_mem_bridge
// AHB-Lite slave front-end for DAP peripheral register blocks. An accepted
// address phase is latched and replayed in the data phase on a single-cycle
// memory-style register interface, with byte strobes derived from size and
// address. Illegal transfers get the two-cycle AHB ERROR response.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   HSEL..HREADY      : AHB-Lite slave inputs (address/control, write data)
//   HREADYOUT, HRESP  : slave ready / response
//   HRDATA            : read data back to the bus
//   ahb_write_en      : one-cycle register write strobe
//   ahb_read_en       : register read enable
//   ahb_addr          : latched register byte address (ADDRWIDTH bits)
//   ahb_wdata         : write data, HWDATA passed through
//   ahb_byte_strobe   : byte lane enables
//   ahb_rdata         : read data from the register block (combinational)
module dap_ahb_mem_bridge #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter bit          READ_WAIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [31:0]          HRDATA,
  output logic                 ahb_write_en,
  output logic                 ahb_read_en,
  output logic [ADDRWIDTH-1:0] ahb_addr,
  output logic [31:0]          ahb_wdata,
  output logic [3:0]           ahb_byte_strobe,
  input  logic [31:0]          ahb_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RWAIT  = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                 vld_p0;
  logic                 legal_p0;
  logic [3:0]           strb_p0;
  logic                 stall;
  logic [ADDRWIDTH-1:0] addr_p1;
  logic                 write_p1;
  logic [3:0]           strb_p1;
  logic [31:0]          rdata_p2;
  logic                 unused_inputs;

  function automatic logic transfer_legal(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd0:    transfer_legal = 1'b1;
      3'd1:    transfer_legal = ~lane[0];
      3'd2:    transfer_legal = (lane == 2'b00);
      default: transfer_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd0:    byte_strobe = 4'b0001 << lane;
      3'd1:    byte_strobe = 4'b0011 << {lane[1], 1'b0};
      3'd2:    byte_strobe = 4'b1111;
      default: byte_strobe = 4'b0000;
    endcase
  endfunction

  // Address bits above the register window and HTRANS[0] are not decoded.
  assign unused_inputs = ^{HADDR[31:ADDRWIDTH], HTRANS[0]};

  // RWAIT and ERR1 are the only cycles that hold the bus; a new address
  // phase cannot be taken there even if HREADY is not wired back to us.
  assign stall = (state_q == ST_RWAIT) || (state_q == ST_ERR1);

  // ---- address phase (p0) ----
  assign vld_p0   = HSEL & HREADY & HTRANS[1] & ~stall;
  assign legal_p0 = transfer_legal(HSIZE, HADDR[1:0]);
  assign strb_p0  = byte_strobe(HSIZE, HADDR[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p1  <= '0;
      write_p1 <= 1'b0;
      strb_p1  <= 4'b0000;
    end else if (vld_p0) begin
      addr_p1  <= HADDR[ADDRWIDTH-1:0];
      write_p1 <= HWRITE;
      strb_p1  <= strb_p0;
    end
  end

  // ---- data phase (p1) / registered read data (p2) ----
  always_ff @(posedge clk) begin
    if (state_q == ST_RWAIT) begin
      rdata_p2 <= ahb_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RWAIT: state_d = ST_ACCESS;
      ST_ERR1:  state_d = ST_ERR2;
      default: begin
        if (vld_p0) begin
          if (!legal_p0) begin
            state_d = ST_ERR1;
          end else if (READ_WAIT && !HWRITE) begin
            state_d = ST_RWAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Enables are masked by reset so a data phase caught by reset never commits.
  always_comb begin
    HREADYOUT    = ~stall;
    HRESP        = 1'b0;
    HRDATA       = 32'h0;
    ahb_write_en = 1'b0;
    ahb_read_en  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        if (write_p1) begin
          ahb_write_en = ~reset;
        end else begin
          ahb_read_en = ~reset;
          if (!reset) begin
            HRDATA = READ_WAIT ? rdata_p2 : ahb_rdata;
          end
        end
      end
      ST_RWAIT: ahb_read_en = ~reset;
      ST_ERR1:  HRESP = 1'b1;
      ST_ERR2:  HRESP = 1'b1;
      default:  ;
    endcase
  end

  assign ahb_addr        = addr_p1;
  assign ahb_byte_strobe = strb_p1;
  assign ahb_wdata       = HWDATA;

endmodule

// File: tb/tb_dap_ahb_mem_bridge.sv
// Bench for dap_ahb_mem_bridge. Instance 0 has zero-wait reads, instance 1
// has one read wait state. Each instance talks to a small register-block
// model; expectations come from a transfer-level reference model.
module tb_dap_ahb_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];
  logic        we        [2];
  logic        re        [2];
  logic [11:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [3:0]  strb      [2];
  logic [31:0] rdata     [2];

  dap_ahb_mem_bridge #(.ADDRWIDTH(12), .READ_WAIT(1'b0)) u0 (
    .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
    .ahb_write_en(we[0]), .ahb_read_en(re[0]), .ahb_addr(addr[0]), .ahb_wdata(wdata[0]),
    .ahb_byte_strobe(strb[0]), .ahb_rdata(rdata[0])
  );

  dap_ahb_mem_bridge #(.ADDRWIDTH(12), .READ_WAIT(1'b1)) u1 (
    .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
    .ahb_write_en(we[1]), .ahb_read_en(re[1]), .ahb_addr(addr[1]), .ahb_wdata(wdata[1]),
    .ahb_byte_strobe(strb[1]), .ahb_rdata(rdata[1])
  );

  // Single-slave interconnect: bus HREADY is the slave's own HREADYOUT.
  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  // Register block model: 16 words per instance, byte-lane writes.
  logic        pm_clr;
  logic [31:0] pmem [2][16];

  assign rdata[0] = re[0] ? pmem[0][addr[0][5:2]] : 32'h0;
  assign rdata[1] = re[1] ? pmem[1][addr[1][5:2]] : 32'h0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        if (pm_clr) begin
          pmem[d][w] <= 32'h0;
        end else if (we[d] && (addr[d][5:2] == 4'(w))) begin
          for (int i = 0; i < 4; i++) begin
            if (strb[d][i]) pmem[d][w][8*i +: 8] <= wdata[d][8*i +: 8];
          end
        end
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [2][16];
  int          vectors;
  int          miscompares;

  // Transfer whose data phase is next (taken at the last acceptance edge).
  bit          p_act;
  bit          p_legal;
  bit          p_wr;
  logic [11:0] p_addr;
  logic [3:0]  p_strb;
  logic [31:0] p_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_rdy",   32'(hreadyout[d]), 32'd1);
    chk("rst_resp",  32'(hresp[d]),     32'd0);
    chk("rst_rdata", hrdata[d],         32'h0);
    chk("rst_we",    32'(we[d]),        32'd0);
    chk("rst_re",    32'(re[d]),        32'd0);
    chk("rst_addr",  32'(addr[d]),      32'h0);
    chk("rst_strb",  32'(strb[d]),      32'h0);
  endtask

  // Check every cycle of the pending transfer's data phase.
  task automatic data_phase(input int d);
    #2;
    if (!p_act) begin
      chk("idle_rdy",   32'(hreadyout[d]), 32'd1);
      chk("idle_resp",  32'(hresp[d]),     32'd0);
      chk("idle_we",    32'(we[d]),        32'd0);
      chk("idle_re",    32'(re[d]),        32'd0);
      chk("idle_rdata", hrdata[d],         32'h0);
    end else if (!p_legal) begin
      chk("err1_rdy",  32'(hreadyout[d]),      32'd1 - 32'd1);
      chk("err1_resp", 32'(hresp[d]),          32'd1);
      chk("err1_en",   32'({we[d], re[d]}),    32'd0);
      @(negedge clk); #2;
      chk("err2_rdy",  32'(hreadyout[d]),      32'd1);
      chk("err2_resp", 32'(hresp[d]),          32'd1);
      chk("err2_en",   32'({we[d], re[d]}),    32'd0);
    end else if (p_wr) begin
      chk("wr_rdy",   32'(hreadyout[d]), 32'd1);
      chk("wr_resp",  32'(hresp[d]),     32'd0);
      chk("wr_we",    32'(we[d]),        32'd1);
      chk("wr_re",    32'(re[d]),        32'd0);
      chk("wr_addr",  32'(addr[d]),      32'(p_addr));
      chk("wr_strb",  32'(strb[d]),      32'(p_strb));
      chk("wr_wdata", wdata[d],          p_wdata);
      chk("wr_rdata", hrdata[d],         32'h0);
      for (int i = 0; i < 4; i++) begin
        if (p_strb[i]) ref_mem[d][p_addr[5:2]][8*i +: 8] = p_wdata[8*i +: 8];
      end
    end else begin
      if (d == 1) begin
        chk("rw_rdy",   32'(hreadyout[d]), 32'd0);
        chk("rw_re",    32'(re[d]),        32'd1);
        chk("rw_we",    32'(we[d]),        32'd0);
        chk("rw_addr",  32'(addr[d]),      32'(p_addr));
        chk("rw_rdata", hrdata[d],         32'h0);
        @(negedge clk); #2;
      end
      chk("rd_rdy",  32'(hreadyout[d]), 32'd1);
      chk("rd_resp", 32'(hresp[d]),     32'd0);
      chk("rd_re",   32'(re[d]),        32'd1);
      chk("rd_we",   32'(we[d]),        32'd0);
      chk("rd_addr", 32'(addr[d]),      32'(p_addr));
      chk("rd_data", hrdata[d],         ref_mem[d][p_addr[5:2]]);
    end
  endtask

  // Drive one address phase while checking the previous transfer's data phase.
  task automatic issue(input int d, input bit sel, input bit act, input bit wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int          nbytes;
    logic [7:0]  mask;
    @(negedge clk);
    hsel[d]   = sel;
    htrans[d] = act ? 2'b10 : 2'b00;
    hwrite[d] = wr;
    hsize[d]  = sz;
    haddr[d]  = a;
    hwdata[d] = (p_act && p_wr) ? p_wdata : $urandom;
    data_phase(d);
    @(posedge clk);
    p_act   = sel && act;
    p_legal = (sz <= 3'd2) && ((a % (32'd1 << sz)) == 32'd0);
    p_wr    = wr;
    p_addr  = a[11:0];
    p_wdata = wd;
    p_strb  = 4'h0;
    if (p_legal) begin
      nbytes = 1 << sz;
      mask   = 8'((9'd1 << nbytes) - 9'd1) << a[1:0];
      p_strb = mask[3:0];
    end
  endtask

  // Reset lands in the data-phase cycle of the pending write.
  task automatic reset_mid_write(input int d);
    @(negedge clk);
    reset     = 1'b1;
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    hwdata[d] = p_wdata;
    #2;
    chk("rst_mid_we", 32'(we[d]), 32'd0);
    chk("rst_mid_re", 32'(re[d]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk_reset_vals(d);
    p_act = 1'b0;
  endtask

  task automatic run_instance(input int d);
    logic [2:0]  sz;
    logic [31:0] a;
    p_act = 1'b0;
    issue(d, 1, 1, 1, 3'd2, 32'h004, 32'hA5A5_5A5A);
    issue(d, 1, 1, 1, 3'd0, 32'h006, $urandom);
    issue(d, 1, 1, 1, 3'd1, 32'h032, $urandom);
    issue(d, 1, 1, 1, 3'd2, 32'h020, 32'h0001_03FF);
    issue(d, 1, 1, 0, 3'd2, 32'h020, 32'h0);
    issue(d, 1, 1, 1, 3'd2, 32'h002, $urandom);
    issue(d, 1, 1, 1, 3'd3, 32'h000, $urandom);
    issue(d, 1, 1, 0, 3'd2, 32'h004, 32'h0);
    issue(d, 1, 0, 1, 3'd2, 32'h008, $urandom);
    issue(d, 0, 1, 1, 3'd2, 32'h010, $urandom);
    issue(d, 1, 1, 0, 3'd1, 32'h006, 32'h0);
    for (int n = 0; n < 80; n++) begin
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if (sz <= 3'd2 && $urandom_range(0, 4) < 3) a = a & ~((32'd1 << sz) - 32'd1);
      issue(d, $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
            sz, a, $urandom);
    end
    issue(d, 1, 1, 1, 3'd2, 32'h008, 32'hDEAD_BEEF);
    reset_mid_write(d);
    issue(d, 1, 1, 0, 3'd2, 32'h008, 32'h0);
    issue(d, 0, 0, 0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    pm_clr      = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; hwdata[d] = 32'h0;
      for (int w = 0; w < 16; w++) ref_mem[d][w] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    pm_clr = 1'b0;
    #2;
    chk_reset_vals(0);
    chk_reset_vals(1);
    run_instance(0);
    run_instance(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dap_ahb_mem_bridge.md
# dap_ahb_mem_bridge

AHB-Lite slave front-end that converts pipelined AHB-Lite transfers from the DAP controller's system bus into the single-cycle memory-style register interface (`ahb_write_en` / `ahb_read_en` / `ahb_addr` / `ahb_wdata` / `ahb_byte_strobe` / `ahb_rdata`) consumed by DAP peripheral register blocks such as the GPIO/IO-delay block. It is the initiator end of that interface:
- latches the address phase;
- replays it in the data phase with generated byte strobes;
- returns read data;
- produces the two-cycle AHB ERROR response for illegal transfers.

## Interface
Parameters:
- `ADDRWIDTH`, 12, width of `ahb_addr`; taken from `HADDR[ADDRWIDTH-1:0]`.
- `READ_WAIT`, 0, 0 = zero-wait reads; 1 = one wait state per read, `HRDATA` registered.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `HSEL` input 1: slave select.
- `HADDR` input 32: address.
- `HTRANS` input 2: transfer type. Only bit 1 is examined: 1 = NONSEQ/SEQ, 0 = IDLE/BUSY.
- `HWRITE` input 1: 1 = write.
- `HSIZE` input 3: 0 = byte, 1 = half, 2 = word; others illegal.
- `HWDATA` input 32: write data, data phase.
- `HREADY` input 1: bus-level ready.
- `HREADYOUT` output 1: slave ready.
- `HRESP` output 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` output 32: read data.
- `ahb_write_en` output 1: register write strobe, one cycle per write.
- `ahb_read_en` output 1: register read enable.
- `ahb_addr` output ADDRWIDTH: register byte address.
- `ahb_wdata` output 32: write data.
- `ahb_byte_strobe` output 4: byte lane enables.
- `ahb_rdata` input 32: read data from the register block, combinational on `ahb_addr`/`ahb_read_en`.

## Operation
- Address phase is accepted when `HSEL & HREADY & HTRANS[1]` is true at a rising edge. On acceptance, latch `HADDR[ADDRWIDTH-1:0]`, `HWRITE`, `HSIZE`, plus a legality flag.
- Illegal transfer:
  - `HSIZE > 2`;
  - `HSIZE == 1` with `HADDR[0] == 1`;
  - `HSIZE == 2` with `HADDR[1:0] != 0`.
- Byte strobe, computed from the latched values:
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << {addr[1], 1'b0}`;
  - word: `4'b1111`.
- States:
  - **IDLE**: no data phase pending.
  - **ACCESS**: legal data phase.
  - **RWAIT**: `READ_WAIT = 1` read, first cycle.
  - **ERR1**, **ERR2**: the two ERROR-response cycles.
- Transitions:
  - **Any state** → on an accepted legal transfer → ACCESS. Exception: a read with `READ_WAIT = 1` → RWAIT.
  - **Any state** → on an accepted illegal transfer → ERR1.
  - **IDLE / ACCESS / ERR2** → otherwise → IDLE.
  - **RWAIT** → ACCESS. During RWAIT, new address phases are not accepted because `HREADYOUT = 0`.
  - **ERR1** → ERR2, unconditionally.
- Write data phase (ACCESS, write): `ahb_write_en = 1` for exactly that cycle; `ahb_wdata = HWDATA` passed through combinationally; `ahb_addr` and strobe from the latch.
- Read data phase:
  - `ahb_read_en = 1` in ACCESS (and in RWAIT).
  - `READ_WAIT = 0`: `HRDATA = ahb_rdata` combinationally in ACCESS.
  - `READ_WAIT = 1`: `ahb_rdata` is captured into a register at the end of RWAIT; `HRDATA` is driven from that register in ACCESS.
- `HRDATA = 0` whenever no read data phase completes that cycle.
- ERR1/ERR2 never assert `ahb_write_en` or `ahb_read_en`.
- `ahb_addr` and `ahb_byte_strobe` hold their last latched values when idle.

## Timing
- Reset values: `HREADYOUT = 1`, `HRESP = 0`, `HRDATA = 0`, `ahb_write_en = 0`, `ahb_read_en = 0`, `ahb_addr = 0`, `ahb_byte_strobe = 0`, state IDLE.
- While `reset` is high, `ahb_write_en` and `ahb_read_en` are forced 0 combinationally. A data phase in progress when reset asserts is aborted; a write in that cycle is not committed.
- Write: address phase at cycle N → `ahb_write_en` in cycle N+1 with `HREADYOUT = 1`. The register updates at the N+1/N+2 edge.
- Read, `READ_WAIT = 0`: data valid in N+1, zero wait.
- Read, `READ_WAIT = 1`:
  - N+1: `HREADYOUT = 0`;
  - N+2: `HREADYOUT = 1` with registered data.
- Error:
  - N+1: `HREADYOUT = 0`, `HRESP = 1`;
  - N+2: `HREADYOUT = 1`, `HRESP = 1`.
- Back-to-back transfers are legal. A write data phase overlapped with the next address phase is the normal pipelined case. Read-after-write to the same register returns the new value with no hazard logic.
- IDLE/BUSY transfers, or `HSEL = 0`: OKAY, zero wait, no enables.

## Test plan
- Word write 0xA5A5_5A5A to 0x004 → `ahb_write_en` pulses one cycle at N+1, `ahb_addr = 0x004`, strobe `4'b1111`, `HREADYOUT = 1`, `HRESP = 0`.
- Byte write to 0x006 then halfword write to 0x032, back-to-back → strobes `4'b0100` then `4'b1100` on consecutive cycles, two `ahb_write_en` pulses.
- `READ_WAIT = 0`, word read 0x020 with `ahb_rdata = 0x0001_03FF` → `HRDATA = 0x0001_03FF` at N+1, no wait state; `READ_WAIT = 1` → `HREADYOUT` low at N+1, data at N+2.
- Word write to 0x002, and `HSIZE = 3` to 0x000 → ERR1/ERR2 sequence (`HREADYOUT` 0→1, `HRESP` 1,1), no `ahb_write_en`/`ahb_read_en`, following legal transfer completes OKAY.
- `HTRANS` = IDLE with `HSEL = 1`, and `HSEL = 0` with NONSEQ → no enables, OKAY, zero wait.
- Assert `reset` in the write data-phase cycle → `ahb_write_en = 0` that cycle, all outputs at reset values next cycle, state IDLE.
